// File: rtl/multdiv.sv
// Sequential signed multiply (Booth) / divide (restoring) unit with one-cycle done pulse.
// Define MULTDIV_BOOTH4_EN for radix-4 Booth multiply (17-cycle latency instead of 33).
module multdiv (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
`ifdef MULTDIV_BOOTH4_EN
  localparam logic [5:0] MUL_ITER = 6'd16;
`else
  localparam logic [5:0] MUL_ITER = 6'd32;
`endif
  localparam logic [5:0] DIV_ITER = 6'd32;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  // hi/lo/q1 form the Booth accumulator {A,Q,q-1}; for divide hi is the remainder, lo the quotient
  logic [5:0]  cnt;
  logic [33:0] hi;
  logic [31:0] lo, mcand;
  logic        q1, neg_q, dz;

  logic [33:0] m_ext, pp, sum;
  logic signed [66:0] sh;
  logic [32:0] rem_sh, trial;
  logic [31:0] abs_a, abs_b;
  logic [32:0] prod_top;

  assign abs_a = data_operandA[31] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[31] ? -data_operandB : data_operandB;
  assign m_ext = {{2{mcand[31]}}, mcand};

  always_comb begin
    pp = '0;
`ifdef MULTDIV_BOOTH4_EN
    case ({lo[1:0], q1})
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    sum = hi + pp;
    sh  = $signed({sum, lo, q1}) >>> 2;
`else
    case ({lo[0], q1})
      2'b01:   pp = m_ext;
      2'b10:   pp = -m_ext;
      default: pp = '0;
    endcase
    sum = hi + pp;
    sh  = $signed({sum, lo, q1}) >>> 1;
`endif
  end

  // Restoring divide step: shift in the next dividend bit, subtract if it fits
  assign rem_sh   = {hi[31:0], lo[31]};
  assign trial    = rem_sh - {1'b0, mcand};
  assign prod_top = {hi[31:0], lo[31]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ctrl_MULT)     state_nxt = MUL;
    else if (ctrl_DIV) state_nxt = DIV;
    else begin
      case (state)
        MUL:     if (cnt == MUL_ITER) state_nxt = DONE;
        DIV:     if (cnt == DIV_ITER) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = (state != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt            <= '0;
      hi             <= '0;
      lo             <= '0;
      q1             <= 1'b0;
      mcand          <= '0;
      neg_q          <= 1'b0;
      dz             <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= data_operandB;
      q1    <= 1'b0;
      mcand <= data_operandA;
    end else if (ctrl_DIV) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= abs_a;
      q1    <= 1'b0;
      mcand <= abs_b;
      neg_q <= data_operandA[31] ^ data_operandB[31];
      dz    <= (data_operandB == '0);
    end else begin
      case (state)
        MUL: begin
          if (cnt != MUL_ITER) begin
            hi  <= sh[66:33];
            lo  <= sh[32:1];
            q1  <= sh[0];
            cnt <= (cnt == 6'h3f) ? cnt : cnt + 6'd1;
          end else begin
            data_result    <= lo;
            data_exception <= !((&prod_top) || !(|prod_top));
          end
        end
        DIV: begin
          if (cnt != DIV_ITER) begin
            hi  <= {1'b0, trial[32] ? rem_sh : trial};
            lo  <= {lo[30:0], ~trial[32]};
            cnt <= (cnt == 6'h3f) ? cnt : cnt + 6'd1;
          end else begin
            // Only a positive quotient of magnitude 2^31 overflows (MIN / -1)
            data_result    <= dz ? '0 : (neg_q ? -lo : lo);
            data_exception <= dz | (!neg_q & lo[31]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv.sv
// Randomized + directed bench for multdiv against an arithmetic reference model.
module tb_multdiv;
`ifdef MULTDIV_BOOTH4_EN
  localparam int LMUL = 17;
`else
  localparam int LMUL = 33;
`endif
  localparam int LDIV = 33;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] a_in, b_in;
  logic        mul_in, div_in;
  logic [31:0] res;
  logic        exc, rdy, busy;

  int checks = 0, passes = 0;
  logic [31:0] prev_r;
  logic        prev_e;

  always #5 clock = ~clock;

  multdiv dut (
    .clock(clock), .resetn(resetn),
    .data_operandA(a_in), .data_operandB(b_in),
    .ctrl_MULT(mul_in), .ctrl_DIV(div_in),
    .data_result(res), .data_exception(exc),
    .data_resultRDY(rdy), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    int ia, ib;
    longint p;
    ia = a; ib = b;
    if (mul) begin
      p = longint'(ia) * longint'(ib);
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (ib == 0) begin
      r = '0; e = 1'b1;
    end else if (a == 32'h8000_0000 && ib == -1) begin
      r = 32'h8000_0000; e = 1'b1;
    end else begin
      r = ia / ib; e = 1'b0;
    end
  endfunction

  // Pulse start on edge k; afterwards scramble operands to prove they were latched.
  task automatic start(input bit dm, input bit dd, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    a_in = a; b_in = b; mul_in = dm; div_in = dd;
    @(posedge clock); #1;
    mul_in = 1'b0; div_in = 1'b0;
    a_in = $urandom; b_in = $urandom;
  endtask

  task automatic run_op(input string tag, input bit dm, input bit dd,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee;
    int          lat;
    bit          held, busy_ok;
    model(dm, a, b, er, ee);
    start(dm, dd, a, b);
    lat = 0; held = 1; busy_ok = 1;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(posedge clock); #1;
      if (rdy) lat = c;
      else begin
        if (res !== prev_r || exc !== prev_e) held = 0;
        if (busy !== 1'b1) busy_ok = 0;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(dm ? LMUL : LDIV));
    chk({tag, " result"}, 64'(res), 64'(er));
    chk({tag, " exception"}, 64'(exc), 64'(ee));
    chk({tag, " busy_at_rdy"}, 64'(busy), 64'd1);
    chk({tag, " held_during_op"}, 64'(held), 64'd1);
    chk({tag, " busy_during_op"}, 64'(busy_ok), 64'd1);
    @(posedge clock); #1;
    chk({tag, " idle_after"}, {62'd0, rdy, busy}, 64'd0);
    chk({tag, " result_kept"}, {31'd0, exc, res}, {31'd0, ee, er});
    prev_r = er; prev_e = ee;
  endtask

  initial begin
    int pulses, lat;
    logic [31:0] r_at;
    logic        e_at;
    logic [31:0] ra, rb;

    resetn = 1'b0; a_in = '0; b_in = '0; mul_in = 1'b0; div_in = 1'b0;
    prev_r = '0; prev_e = 1'b0;
    #12;
    chk("reset outputs", {29'd0, exc, rdy, busy, res}, 64'd0);
    @(negedge clock); resetn = 1'b1;

    run_op("mul 7*-3", 1, 0, 32'd7, -32'sd3);
    run_op("mul 2^16*2^16", 1, 0, 32'h0001_0000, 32'h0001_0000);
    run_op("mul min*min", 1, 0, 32'h8000_0000, 32'h8000_0000);
    run_op("mul min*-1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div -7/2", 0, 1, -32'sd7, 32'd2);
    run_op("div 5/0", 0, 1, 32'd5, 32'd0);
    run_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div min/1", 0, 1, 32'h8000_0000, 32'd1);
    run_op("mul+div both", 1, 1, 32'd1234, -32'sd77);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
      run_op("rand mul", 1, 0, ra, rb);
    end
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? 32'($signed(8'($urandom))) : $urandom;
      run_op("rand div", 0, 1, ra, rb);
    end

    // Abort a divide with a multiply at edge k+10
    start(0, 1, 32'd100, 32'd7);
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clock); #1;
      if (rdy) pulses++;
    end
    start(1, 0, 32'd6, 32'd6);
    lat = 0; r_at = '0; e_at = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock); #1;
      if (rdy) begin
        pulses++;
        if (lat == 0) begin lat = c; r_at = res; e_at = exc; end
      end
    end
    chk("abort pulses", 64'(pulses), 64'd1);
    chk("abort latency", 64'(lat), 64'(LMUL));
    chk("abort result", 64'(r_at), 64'd36);
    chk("abort exception", 64'(e_at), 64'd0);

    // Asynchronous reset in the middle of a multiply
    start(1, 0, 32'd123456, -32'sd789);
    for (int c = 1; c <= 5; c++) @(posedge clock);
    #1 resetn = 1'b0;
    #1 chk("async reset outputs", {29'd0, exc, rdy, busy, res}, 64'd0);
    @(negedge clock); @(negedge clock); resetn = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clock); #1;
      if (rdy) pulses++;
    end
    chk("no rdy after reset", 64'(pulses), 64'd0);
    prev_r = '0; prev_e = 1'b0;
    run_op("first after reset", 0, 1, 32'd100, 32'd7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 data_operandA  input  32  signed two's-complement multiplicand or dividend.
REQ-005 data_operandB  input  32  signed two's-complement multiplier or divisor.
REQ-006 ctrl_MULT  input  1  single-cycle start pulse for multiply.
REQ-007 ctrl_DIV  input  1  single-cycle start pulse for divide.
REQ-008 data_result  output  32  low 32 bits of the product, or the quotient.
REQ-009 data_exception  output  1  overflow or divide-by-zero flag; valid when data_resultRDY is high.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while an operation is in progress.

Function
REQ-012 The FSM SHALL have four states, IDLE, MUL, DIV and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-013 Operands SHALL be latched on the start edge, and input changes after that edge SHALL NOT affect the result.
REQ-014 If ctrl_MULT and ctrl_DIV are high on the same edge, multiply SHALL win.
REQ-015 A start pulse in any state, including MUL, DIV or DONE, SHALL abort the current operation and restart with the new operands; the aborted operation SHALL produce no data_resultRDY.
REQ-016 Latency is counted from the start edge k: data_resultRDY SHALL be high in the cycle after edge k+L; L is given in Configuration for multiply and is 33 for divide.
REQ-017 busy SHALL be high from edge k+1 through the data_resultRDY cycle inclusive.
REQ-018 Multiply SHALL form the full 64-bit signed product using Booth recoding; data_result = product[31:0].
REQ-019 Multiply data_exception SHALL be 1 iff product[63:31] are not all equal.
REQ-020 Divide SHALL use a 32-iteration restoring algorithm on operand magnitudes, with the quotient truncated toward zero and negated when the operand signs differ; the remainder SHALL be discarded.
REQ-021 Divide by zero SHALL give data_result = 0 and data_exception = 1, with the normal latency of 33.
REQ-022 Dividing 0x80000000 by 0xFFFFFFFF SHALL give data_result = 0x80000000 and data_exception = 1.
REQ-023 data_result and data_exception SHALL hold their last completed values until the next completion; they SHALL NOT change during an operation.
REQ-024 The iteration counter SHALL be 6 bits and SHALL saturate; it SHALL never wrap to re-enter an operation.

Reset
REQ-025 While resetn is 0, the block SHALL asynchronously force: state = IDLE, data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0, counter and internal registers = 0.
REQ-026 A reset asserted mid-operation SHALL abandon the operation and produce no completion pulse.
REQ-027 After resetn deasserts, the first start edge SHALL be honoured.

Configuration
REQ-028 The macro MULTDIV_BOOTH4_EN selects the multiply radix.
REQ-029 With MULTDIV_BOOTH4_EN defined, multiply SHALL use radix-4 Booth with 16 iterations plus 1 finalize cycle, so L = 17.
REQ-030 Without MULTDIV_BOOTH4_EN, multiply SHALL use radix-2 Booth with 32 iterations plus 1 finalize cycle, so L = 33.
REQ-031 Divide behaviour SHALL be identical with and without MULTDIV_BOOTH4_EN.

Verification
REQ-032 Multiply 7 by -3 with MULTDIV_BOOTH4_EN defined -> data_resultRDY after edge k+17, data_result = 0xFFFFFFEB, data_exception = 0; without the macro -> the same values after edge k+33.
REQ-033 Multiply 0x00010000 by 0x00010000 -> data_result = 0x00000000, data_exception = 1.
REQ-034 Divide -7 by 2 -> data_result = 0xFFFFFFFD, data_exception = 0, data_resultRDY after edge k+33; divide 5 by 0 -> data_result = 0, data_exception = 1.
REQ-035 Divide 0x80000000 by -1 -> data_result = 0x80000000, data_exception = 1.
REQ-036 Start a divide 100/7, then pulse ctrl_MULT with 6 and 6 at edge k+10 -> exactly one data_resultRDY, with data_result = 36 at the multiply latency from edge k+10.
REQ-037 Assert resetn = 0 at edge k+5 of a multiply -> all outputs are 0 immediately, and there is no data_resultRDY within 40 cycles.
